glb_burst_reader: RTL and testbench
===================================

GLB_BURST_READER -- requirements
Module: glb_burst_reader

Interface
REQ-001 SHALL have parameter INWIDTH, default 16, data word width.
REQ-002 SHALL have parameter NUM_ELEM, default 295160, buffer depth in words; ADDR_WIDTH = $clog2(NUM_ELEM).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, burst length width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth; it SHALL be at least RD_LATENCY+1.
REQ-005 SHALL have the ports below, one clock, asynchronous active-low reset:
  clk        in   1           sole clock, rising edge
  reset      in   1           asynchronous, active-low reset
  cmd_valid  in   1           burst command offered
  cmd_ready  out  1           command accepted when both are high
  cmd_addr   in   ADDR_WIDTH  start word address
  cmd_len    in   LEN_WIDTH   word count; 0 = no-op
  ram_en     out  1           buffer port enable
  ram_we     out  1           buffer write enable, constant 0
  ram_addr   out  ADDR_WIDTH  buffer read address
  ram_dout   in   INWIDTH     buffer read data, RD_LATENCY cycles after address
  out_valid  out  1           stream word valid
  out_ready  in   1           stream consumer ready
  out_data   out  INWIDTH     stream word
  out_last   out  1           final word of burst
  busy       out  1           burst in progress

Function
REQ-006 SHALL use FSM states IDLE, ISSUE, DRAIN.
REQ-007 IDLE: cmd_ready=1; on handshake with cmd_len!=0, SHALL latch address and length and go to ISSUE next cycle; with cmd_len==0, SHALL stay IDLE and emit nothing.
REQ-008 ISSUE/DRAIN: cmd_ready=0, busy=1.
REQ-009 ram_en SHALL be held at 1 for the whole of ISSUE and DRAIN, so that a buffer whose second output stage is gated by enable still advances; ram_en=0 in IDLE.
REQ-010 In ISSUE, a read SHALL be issued only in a cycle where (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
REQ-011 On each issued read, the address SHALL increment by 1 and remaining SHALL decrement by 1.
REQ-012 Address after NUM_ELEM-1 SHALL wrap to 0.
REQ-013 In non-issue cycles, ram_addr SHALL hold its value; the resulting dummy reads SHALL be discarded.
REQ-014 An RD_LATENCY-bit valid/last shift register SHALL track issued reads; ram_dout SHALL be pushed into the FIFO exactly when a tagged bit exits.
REQ-015 When the last read is issued, the FSM SHALL move to DRAIN.
REQ-016 DRAIN SHALL return to IDLE in the cycle after the out_last word handshakes.
REQ-017 out_data/out_valid/out_last SHALL come from the FIFO head.
REQ-018 FIFO pop SHALL occur on out_valid && out_ready; simultaneous push and pop SHALL be legal at any occupancy.
REQ-019 out_data SHALL stay stable while out_valid && !out_ready.
REQ-020 Minimum latency: command handshake at cycle 0 gives first out_valid at cycle RD_LATENCY+2.
REQ-021 With out_ready held at 1, throughput SHALL be 1 word/cycle.
REQ-022 Words SHALL be delivered in address order with no loss or duplication under any out_ready pattern.

Reset
REQ-023 Asserting reset (low) SHALL immediately force IDLE, clear the FIFO, counters and shift register, and drive cmd_ready=0, ram_en=0, ram_we=0, ram_addr=0, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-024 After release, cmd_ready SHALL rise on the first clk edge.
REQ-025 Reset mid-burst SHALL discard all in-flight data, with no partial burst resuming.

Configuration
REQ-026 With GLB_READER_STATS_EN defined, SHALL add 32-bit outputs stat_words and stat_stall: stat_words counts delivered words, stat_stall counts out_valid && !out_ready cycles; both SHALL saturate and be cleared by reset.
REQ-027 Without GLB_READER_STATS_EN, these ports SHALL exist but be tied to 0, and no counter logic SHALL be present.

Structure
REQ-028 Package glb_pkg SHALL hold RD_LATENCY (=2), the FSM state enum, and the default width constants.
REQ-029 The output FIFO SHALL be sub-module glb_reader_fifo: synchronous, with count output and a first-word-fall-through head.

Verification
REQ-030 cmd_addr=0x10, cmd_len=4, out_ready=1, RAM preloaded with 0xA0..0xA3 -> out_data A0,A1,A2,A3 on 4 consecutive cycles starting at cycle 4, out_last on A3, busy low at cycle 8.
REQ-031 cmd_len=8, out_ready low for the first 10 cycles -> at most FIFO_DEPTH reads outstanding, then 8 words in order, none lost.
REQ-032 cmd_addr=NUM_ELEM-2, cmd_len=4 -> addresses NUM_ELEM-2, NUM_ELEM-1, 0, 1.
REQ-033 cmd_len=0 -> cmd_ready stays 1, ram_en stays 0, no out_valid; a following cmd_len=1 -> one word with out_last=1.
REQ-034 reset asserted at the 3rd word of a 16-word burst -> all outputs reach reset values asynchronously; a new cmd_len=2 burst delivers exactly 2 correct words.
REQ-035 With GLB_READER_STATS_EN defined, a 6-word burst with 3 stall cycles -> stat_words=6, stat_stall=3.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared constants and FSM state type for the burst reader.
package glb_pkg;

   localparam int RD_LATENCY     = 2;
   localparam int DEF_INWIDTH    = 16;
   localparam int DEF_NUM_ELEM   = 295160;
   localparam int DEF_LEN_WIDTH  = 16;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/glb_reader_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
module glb_reader_fifo #(
   parameter  int WIDTH = 17,
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = (count != '0) ? mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the count gates visibility, so stale entries never reach the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/glb_burst_reader.sv
// Streams a burst of words out of a latency-RD_LATENCY buffer with credit-limited issue.
// Optional GLB_READER_STATS_EN adds delivered-word and stall counters.
module glb_burst_reader
   import glb_pkg::*;
#(
   parameter  int INWIDTH    = DEF_INWIDTH,
   parameter  int NUM_ELEM   = DEF_NUM_ELEM,
   parameter  int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int ADDR_WIDTH = $clog2(NUM_ELEM)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [INWIDTH-1:0]    ram_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INWIDTH-1:0]    out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic [31:0]           stat_words,
   output logic [31:0]           stat_stall
);

   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int IW    = $clog2(RD_LATENCY + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   state_t                state, next_state;
   logic                  rdy_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  remain_q;
   logic [RD_LATENCY-1:0] vld_sr, last_sr;
   logic [IW-1:0]         inflight;
   logic [CW-1:0]         fifo_count;
   logic [INWIDTH:0]      fifo_head;
   logic                  accept, issue, last_issue, out_fire;

   assign accept     = (state == IDLE) && rdy_q && cmd_valid && (cmd_len != '0);
   assign out_fire   = out_valid && out_ready;
   assign last_issue = issue && (remain_q == LEN_WIDTH'(1));
   assign ram_we     = 1'b0;
   assign ram_addr   = addr_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight += IW'(vld_sr[i]);
   end

   // Credit check: reads in the pipe plus words held must leave room in the FIFO.
   assign issue = (state == ISSUE) &&
                  ((OCC_W'(inflight) + OCC_W'(fifo_count)) < OCC_W'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept)                 next_state = ISSUE;
         ISSUE:   if (last_issue)             next_state = DRAIN;
         DRAIN:   if (out_fire && out_last)   next_state = IDLE;
         default:                             next_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      ram_en    = 1'b0;
      unique case (state)
         IDLE:         cmd_ready = rdy_q;
         ISSUE, DRAIN: begin
            busy   = 1'b1;
            ram_en = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q    <= 1'b0;
         addr_q   <= '0;
         remain_q <= '0;
         vld_sr   <= '0;
         last_sr  <= '0;
      end else begin
         rdy_q   <= 1'b1;
         vld_sr  <= {vld_sr[RD_LATENCY-2:0], issue};
         last_sr <= {last_sr[RD_LATENCY-2:0], last_issue};
         if (accept) begin
            addr_q   <= cmd_addr;
            remain_q <= cmd_len;
         end else if (issue) begin
            addr_q   <= (addr_q == ADDR_WIDTH'(NUM_ELEM - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - LEN_WIDTH'(1);
         end
      end
   end

   glb_reader_fifo #(
      .WIDTH (INWIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (vld_sr[RD_LATENCY-1]),
      .push_data ({last_sr[RD_LATENCY-1], ram_dout}),
      .pop       (out_fire),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_head[INWIDTH-1:0];
   assign out_last  = fifo_head[INWIDTH];

`ifdef GLB_READER_STATS_EN
   logic [31:0] words_q, stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         words_q <= '0;
         stall_q <= '0;
      end else begin
         if (out_fire && (words_q != '1))                 words_q <= words_q + 32'd1;
         if (out_valid && !out_ready && (stall_q != '1))  stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_words = words_q;
   assign stat_stall = stall_q;
`else
   assign stat_words = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_glb_burst_reader.sv
// Self-checking bench: queue-based reference of burst contents plus directed literal pins.
module tb_glb_burst_reader;

   localparam int INWIDTH    = 16;
   localparam int NUM_ELEM   = 295160;
   localparam int LEN_WIDTH  = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int AW         = $clog2(NUM_ELEM);
`ifdef GLB_READER_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [AW-1:0]        cmd_addr = '0;
   logic [LEN_WIDTH-1:0] cmd_len = '0;
   logic                 ram_en, ram_we;
   logic [AW-1:0]        ram_addr;
   logic [INWIDTH-1:0]   ram_dout;
   logic                 out_valid, out_last, busy;
   logic                 out_ready = 1'b1;
   logic [INWIDTH-1:0]   out_data;
   logic [31:0]          stat_words, stat_stall;

   glb_burst_reader #(
      .INWIDTH(INWIDTH), .NUM_ELEM(NUM_ELEM), .LEN_WIDTH(LEN_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy),
      .stat_words(stat_words), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Buffer content is a fixed function of address, so expectations need no storage.
   function automatic logic [INWIDTH-1:0] ram_word(input int a);
      return INWIDTH'(a + 'h90);
   endfunction

   // Two-stage enable-gated read pipeline.
   logic [INWIDTH-1:0] s1 = '0, s2 = '0;
   always @(posedge clk) if (ram_en) begin
      s1 <= ram_word(int'(ram_addr));
      s2 <= s1;
   end
   assign ram_dout = s2;

   typedef struct {
      logic [INWIDTH-1:0] data;
      logic               last;
   } word_t;

   word_t              exp_q[$];
   int                 addr_seen[$];
   logic [INWIDTH-1:0] del_data[$];
   int                 del_rel[$];
   bit                 del_last[$];
   bit                 busy_m = 0, mon_en = 0, prev_en = 0, prev_busy = 0;
   logic [AW-1:0]      prev_addr = '0;
   int adv = 0, popped = 0, cur_len = 0, hs_cyc = 0, cyc = 0;
   int words_m = 0, stall_m = 0, first_valid_rel = -1, fall_rel = -1;
   int ready_mode = 0;

   always @(posedge clk) cyc = cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Compare process: every cycle outside reset, judged at the falling edge.
   always @(negedge clk) if (mon_en) begin
      bit    rdy_exp;
      word_t w;
      rdy_exp = !busy_m;
      check("busy", busy, busy_m);
      check("cmd_ready", cmd_ready, rdy_exp);
      check("ram_en", ram_en, busy_m);
      check("ram_we", ram_we, 0);
      check("stat_words", stat_words, STATS_EN ? words_m : 0);
      check("stat_stall", stat_stall, STATS_EN ? stall_m : 0);
      if (prev_en && ram_en && ram_addr != prev_addr) adv++;
      if (ram_en && (addr_seen.size() == 0 || addr_seen[$] != int'(ram_addr)))
         addr_seen.push_back(int'(ram_addr));
      if (busy_m) check("outstanding_le_depth", 64'(adv - popped <= FIFO_DEPTH), 1);
      if (prev_busy && !busy) fall_rel = cyc - hs_cyc;
      if (out_valid && first_valid_rel < 0) first_valid_rel = cyc - hs_cyc;
      if (out_valid && !out_ready) stall_m++;
      if (out_valid) begin
         if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
         else begin
            check("out_data", out_data, exp_q[0].data);
            check("out_last", out_last, exp_q[0].last);
            if (out_ready) begin
               w = exp_q.pop_front();
               popped++;
               words_m++;
               del_data.push_back(out_data);
               del_rel.push_back(cyc - hs_cyc);
               del_last.push_back(out_last);
               if (w.last) begin
                  check("issued_reads", adv, cur_len);
                  busy_m = 0;
               end
            end
         end
      end
      if (cmd_valid && rdy_exp && cmd_len != '0) begin
         for (int i = 0; i < int'(cmd_len); i++) begin
            w.data = ram_word((int'(cmd_addr) + i) % NUM_ELEM);
            w.last = (i == int'(cmd_len) - 1);
            exp_q.push_back(w);
         end
         busy_m = 1; adv = 0; popped = 0; cur_len = int'(cmd_len); hs_cyc = cyc;
         first_valid_rel = -1; fall_rel = -1;
         addr_seen.delete(); del_data.delete(); del_rel.delete(); del_last.delete();
      end
      prev_en   = ram_en;
      prev_addr = ram_addr;
      prev_busy = busy;
   end

   task automatic check_reset_outs(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 0);
      check({tag, "_ram_en"}, ram_en, 0);
      check({tag, "_ram_we"}, ram_we, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_stat_words"}, stat_words, 0);
   endtask

   // Asserts reset at the call time (callers keep it off the clock edges).
   task automatic apply_reset(input string tag);
      mon_en = 0;
      cmd_valid = 1'b0;
      reset = 1'b0;
      #1 check_reset_outs(tag);
      repeat (2) @(posedge clk);
      #1 check_reset_outs({tag, "_held"});
      exp_q.delete(); addr_seen.delete(); del_data.delete(); del_rel.delete(); del_last.delete();
      busy_m = 0; adv = 0; popped = 0; words_m = 0; stall_m = 0;
      prev_en = 0; prev_busy = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("cmd_ready_before_first_edge", cmd_ready, 0);
      @(posedge clk);
      #1 check("cmd_ready_after_first_edge", cmd_ready, 1);
      mon_en = 1;
   endtask

   task automatic send_cmd(input int addr, input int len);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_len   = LEN_WIDTH'(len);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 2000; n++) begin
         @(posedge clk);
         #2;
         if (!busy_m && exp_q.size() == 0) break;
      end
      check("wait_idle_in_budget", 64'(n < 2000), 1);
   endtask

   initial begin
      int w0, n;
      #2;
      apply_reset("reset0");

      // Minimum-latency burst with literal timing and data.
      ready_mode = 0;
      send_cmd('h10, 4);
      wait_idle();
      repeat (2) @(negedge clk);
      #1;
      check("b4_count", del_data.size(), 4);
      for (int i = 0; i < 4 && i < del_data.size(); i++) begin
         check($sformatf("b4_data%0d", i), del_data[i], 'hA0 + i);
         check($sformatf("b4_cycle%0d", i), del_rel[i], 4 + i);
      end
      if (del_last.size() == 4) begin
         check("b4_last_on_A3", del_last[3], 1);
         check("b4_no_early_last", del_last[0], 0);
      end
      check("b4_first_valid_cycle", first_valid_rel, 4);
      check("b4_busy_low_cycle", fall_rel, 8);

      // Address wrap at the top of the buffer.
      send_cmd(NUM_ELEM - 2, 4);
      wait_idle();
      check("wrap_addr_count_ge4", 64'(addr_seen.size() >= 4), 1);
      if (addr_seen.size() >= 4) begin
         check("wrap_addr0", addr_seen[0], NUM_ELEM - 2);
         check("wrap_addr1", addr_seen[1], NUM_ELEM - 1);
         check("wrap_addr2", addr_seen[2], 0);
         check("wrap_addr3", addr_seen[3], 1);
      end

      // Zero-length command is a no-op; a single-word burst follows.
      w0 = words_m;
      send_cmd(5, 0);
      repeat (5) @(negedge clk);
      #1;
      check("len0_no_words", words_m, w0);
      check("len0_ram_en", ram_en, 0);
      check("len0_cmd_ready", cmd_ready, 1);
      send_cmd(7, 1);
      wait_idle();
      check("len1_count", del_data.size(), 1);
      if (del_data.size() == 1) begin
         check("len1_data", del_data[0], 'h97);
         check("len1_last", del_last[0], 1);
      end

      // Consumer stalled: issue stops at FIFO_DEPTH, then all 8 words drain in order.
      ready_mode = 2;
      send_cmd(100, 8);
      repeat (10) @(negedge clk);
      #1;
      check("stall_issued_reads", adv, FIFO_DEPTH);
      check("stall_no_delivery", del_data.size(), 0);
      ready_mode = 0;
      wait_idle();
      check("stall_count", del_data.size(), 8);
      for (int i = 0; i < 8 && i < del_data.size(); i++)
         check($sformatf("stall_data%0d", i), del_data[i], 'hF4 + i);

      // Reset on the 3rd word of a 16-word burst.
      send_cmd(200, 16);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (del_data.size() == 2) break;
      end
      check("midreset_reached_word3", 64'(n < 100), 1);
      apply_reset("midreset");
      send_cmd(300, 2);
      wait_idle();
      repeat (6) @(negedge clk);
      #1;
      check("after_reset_count", del_data.size(), 2);
      if (del_data.size() == 2) begin
         check("after_reset_data0", del_data[0], 'h1BC);
         check("after_reset_data1", del_data[1], 'h1BD);
      end

      // Statistics: 6 words with exactly 3 stall cycles.
      @(negedge clk);
      #2 apply_reset("stats_reset");
      ready_mode = 2;
      send_cmd(50, 6);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         #1;
         if (out_valid) break;
      end
      check("stats_valid_seen", 64'(n < 50), 1);
      @(negedge clk);
      @(negedge clk);
      #1 ready_mode = 0;
      wait_idle();
      repeat (2) @(negedge clk);
      #1;
      check("stats_model_stall", stall_m, 3);
      check("stats_words_final", stat_words, STATS_EN ? 6 : 0);
      check("stats_stall_final", stat_stall, STATS_EN ? 3 : 0);

      // Randomized bursts and consumer back-pressure.
      for (int k = 0; k < 40; k++) begin
         int a;
         ready_mode = int'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? NUM_ELEM - int'($urandom_range(1, 8))
                                         : int'($urandom_range(0, NUM_ELEM - 1));
         send_cmd(a, int'($urandom_range(0, 12)));
         wait_idle();
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
